ram_loader: RTL
===============

# ram_loader

Upstream feeder for the convolution top module: accepts a valid/ready word stream, writes the first FILTER_WORDS words into filter RAM (bvm) and the next INPUT_WORDS words into input RAM (dim), then pulses the top module's go and waits for its finish. Sits between the host/stream source and the filter_ram/input_ram write ports, and owns the go/finish handshake of the convolution engine.

## Interface
- FILTER_WORDS, 9, words written to filter RAM per frame (1..512)
- INPUT_WORDS, 256, words written to input RAM per frame (1..512)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- xxx__ldr__start  in  1  one-cycle request to load a frame; honoured only in IDLE
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  16  stream word
- ldr__bvm__address / enable / write / data  out  9/1/1/16  filter RAM write port
- ldr__dim__address / enable / write / data  out  9/1/1/16  input RAM write port
- ldr__dut__go  out  1  one-cycle start pulse to the convolution top module
- dut__ldr__finish  in  1  completion from the convolution top module
- ldr__xxx__done  out  1  one-cycle pulse: frame computed
- ldr__xxx__busy  out  1  high whenever state is not IDLE
- ldr__xxx__error  out  1  sticky checksum error (only with LOADER_CHECKSUM_EN)

## Operation
- States: IDLE, LOAD_FILT, LOAD_INP, CHECK (macro only), DRAIN, GO, WAIT_FIN.
- IDLE: s_ready=0; start -> LOAD_FILT, word counter cleared, error cleared.
- Beat = s_valid & s_ready. s_ready = 1 in LOAD_FILT, LOAD_INP, CHECK; 0 elsewhere.
- LOAD_FILT: beat k writes bvm[k]; after beat FILTER_WORDS-1 -> LOAD_INP, counter cleared.
- LOAD_INP: beat k writes dim[k]; after beat INPUT_WORDS-1 -> CHECK (macro) or DRAIN.
- DRAIN: one cycle, final dim write strobe presented -> GO.
- GO: ldr__dut__go=1 for exactly one cycle -> WAIT_FIN.
- WAIT_FIN: wait for dut__ldr__finish=1 -> IDLE, done=1 that same transition cycle+1 (one-cycle pulse).
- start outside IDLE ignored; finish outside WAIT_FIN ignored; s_data ignored when s_ready=0.
- Counter width 9 bits; terminal compare against parameter-1, never wraps within a frame.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, counter 0, all outputs 0 (addresses, data, enables, writes, go, done, busy, error, s_ready).
- Write latency: beat accepted at edge n -> enable=write=1, address=k, data=word during cycle n..n+1 only; enable and write always equal.
- Back-to-back beats: one write per cycle, zero bubbles, including across the filter->input boundary (s_ready stays 1).
- s_valid low mid-frame: no write, counter holds, s_ready stays 1.
- go asserted 2 cycles after the last input beat (after DRAIN); minimum start-to-go = FILTER_WORDS+INPUT_WORDS+2 cycles with continuous valid.
- Reset mid-frame: immediate abort to IDLE; RAM contents undefined; no go issued.

## Configuration
- LOADER_CHECKSUM_EN defined: after the last input word, CHECK accepts one extra word compared against the 16-bit wrap-around sum of all FILTER_WORDS+INPUT_WORDS words. Match -> DRAIN. Mismatch -> IDLE, error=1 (sticky until next start), no go; the final dim write still completes.
- Undefined: no CHECK state, no accumulator, error tied 0, frame is exactly FILTER_WORDS+INPUT_WORDS words.

## Structure
- loader_pkg: state enum, ADDR_W=9, DATA_W=16, RAM depth 512.
- One sub-module: ldr_beat_counter (9-bit clear/increment counter with terminal flag), reused for both phases.
- Write-port registers and FSM in ram_loader.

## Test plan
- Reset mid-LOAD_INP (word 100) -> all outputs 0 next cycle, busy=0; new start reloads from bvm[0].
- FILTER_WORDS=9, INPUT_WORDS=256, continuous valid, data=index -> bvm[0..8]=0..8, dim[0..255]=9..264, go exactly once at start+267 cycles.
- s_valid toggled every other cycle -> no duplicated or skipped addresses; write count 265.
- start during WAIT_FIN and finish pulsed in IDLE -> both ignored; done only after real finish, one cycle wide.
- LOADER_CHECKSUM_EN, correct sum word -> go pulses; sum+1 -> error=1, go never asserts, busy=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and widths for the RAM loader.
// Optional build macro: LOADER_CHECKSUM_EN adds the CHECK state.
package loader_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RAM_DEPTH = 512;

  typedef enum logic [2:0] {
    StIdle,
    StLoadFilt,
    StLoadInp,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDrain,
    StGo,
    StWaitFin
  } ldr_state_e;

endpackage

// File: rtl/ram_loader_if.sv
// Valid/ready word stream feeding the RAM loader.
interface ram_loader_if;
  import loader_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/ldr_beat_counter.sv
// Clear/increment beat counter with a terminal flag against a runtime limit.
module ldr_beat_counter #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic             last_o
);

  logic [Width-1:0] count_q;

  // Clear has priority so a phase change restarts at zero on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == limit_i);

endmodule

// File: rtl/ram_loader.sv
// Stream-to-RAM frame loader: fills filter RAM then input RAM, then runs the
// go/finish handshake of the convolution engine.
// Optional build macro: LOADER_CHECKSUM_EN (trailing checksum word + sticky error).
module ram_loader
  import loader_pkg::*;
#(
  parameter int unsigned FILTER_WORDS = 9,
  parameter int unsigned INPUT_WORDS  = 256
) (
  input  logic              clk,
  input  logic              reset,
  ram_loader_if.slave       str,
  input  logic              xxx__ldr__start,
  output logic [ADDR_W-1:0] ldr__bvm__address,
  output logic              ldr__bvm__enable,
  output logic              ldr__bvm__write,
  output logic [DATA_W-1:0] ldr__bvm__data,
  output logic [ADDR_W-1:0] ldr__dim__address,
  output logic              ldr__dim__enable,
  output logic              ldr__dim__write,
  output logic [DATA_W-1:0] ldr__dim__data,
  output logic              ldr__dut__go,
  input  logic              dut__ldr__finish,
  output logic              ldr__xxx__done,
  output logic              ldr__xxx__busy,
  output logic              ldr__xxx__error
);

  localparam logic [ADDR_W-1:0] FiltLast = ADDR_W'(FILTER_WORDS - 1);
  localparam logic [ADDR_W-1:0] InpLast  = ADDR_W'(INPUT_WORDS - 1);

  ldr_state_e        state_q, state_d;
  logic              beat, start_acc;
  logic              cnt_clr, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt, cnt_limit;

  logic              bvm_en_q, dim_en_q, done_q;
  logic [ADDR_W-1:0] bvm_addr_q, dim_addr_q;
  logic [DATA_W-1:0] bvm_data_q, dim_data_q;

  assign beat      = str.s_valid & str.s_ready;
  assign start_acc = (state_q == StIdle) & xxx__ldr__start;
  assign cnt_limit = (state_q == StLoadFilt) ? FiltLast : InpLast;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              err_q;
  logic              chk_fail;

  assign str.s_ready = (state_q == StLoadFilt) | (state_q == StLoadInp) | (state_q == StCheck);
`else
  assign str.s_ready = (state_q == StLoadFilt) | (state_q == StLoadInp);
`endif

  ldr_beat_counter #(
    .Width(ADDR_W)
  ) u_beat_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .limit_i(cnt_limit),
    .count_o(cnt),
    .last_o (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_fail = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (xxx__ldr__start) begin
          state_d = StLoadFilt;
          cnt_clr = 1'b1;
        end
      end
      StLoadFilt: begin
        if (beat) begin
          if (cnt_last) begin
            state_d = StLoadInp;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      StLoadInp: begin
        if (beat) begin
          if (cnt_last) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDrain;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (beat) begin
          if (str.s_data == sum_q) begin
            state_d = StDrain;
          end else begin
            state_d  = StIdle;
            chk_fail = 1'b1;
          end
        end
      end
`endif
      StDrain:   state_d = StGo;
      StGo:      state_d = StWaitFin;
      StWaitFin: begin
        if (dut__ldr__finish) begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  // Running wrap-around sum of frame words; error sticks until the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (start_acc) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (beat && (state_q != StCheck)) begin
        sum_q <= sum_q + str.s_data;
      end
      if (chk_fail) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ldr__xxx__error = err_q;
`else
  assign ldr__xxx__error = 1'b0;
`endif

  // RAM write ports: one registered strobe per accepted beat; address/data hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bvm_en_q   <= 1'b0;
      bvm_addr_q <= '0;
      bvm_data_q <= '0;
      dim_en_q   <= 1'b0;
      dim_addr_q <= '0;
      dim_data_q <= '0;
    end else begin
      bvm_en_q <= beat && (state_q == StLoadFilt);
      dim_en_q <= beat && (state_q == StLoadInp);
      if (beat && (state_q == StLoadFilt)) begin
        bvm_addr_q <= cnt;
        bvm_data_q <= str.s_data;
      end
      if (beat && (state_q == StLoadInp)) begin
        dim_addr_q <= cnt;
        dim_data_q <= str.s_data;
      end
    end
  end

  // Done pulses the cycle after finish is seen in WAIT_FIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == StWaitFin) && dut__ldr__finish;
    end
  end

  assign ldr__bvm__address = bvm_addr_q;
  assign ldr__bvm__enable  = bvm_en_q;
  assign ldr__bvm__write   = bvm_en_q;
  assign ldr__bvm__data    = bvm_data_q;
  assign ldr__dim__address = dim_addr_q;
  assign ldr__dim__enable  = dim_en_q;
  assign ldr__dim__write   = dim_en_q;
  assign ldr__dim__data    = dim_data_q;
  assign ldr__dut__go      = (state_q == StGo);
  assign ldr__xxx__busy    = (state_q != StIdle);
  assign ldr__xxx__done    = done_q;

endmodule
